// File: rtl/axi_tdd_ng_counter_pkg.sv
// Shared types and default widths for the TDD frame timing core.
// The optional frame index output is enabled by TDD_NG_FRAME_INDEX_EN.
package axi_tdd_ng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        WAITING = 2'd2,
        RUNNING = 2'd3
    } state_t;

    localparam int DEFAULT_REGISTER_WIDTH    = 32;
    localparam int DEFAULT_BURST_COUNT_WIDTH = 32;

endpackage

// File: rtl/axi_tdd_ng_counter_if.sv
// Control/status bundle between the TDD frame timing core and its register/compare logic.
// TDD_NG_FRAME_INDEX_EN adds the tdd_frame_index signal.
interface axi_tdd_ng_counter_if
    import axi_tdd_ng_pkg::*;
#(
    parameter int REGISTER_WIDTH    = DEFAULT_REGISTER_WIDTH,
    parameter int BURST_COUNT_WIDTH = DEFAULT_BURST_COUNT_WIDTH
);

    logic                         tdd_enable;
    logic                         tdd_sync;
    logic                         tdd_sync_rst;
    logic [REGISTER_WIDTH-1:0]    tdd_startup_delay;
    logic [REGISTER_WIDTH-1:0]    tdd_frame_length;
    logic [BURST_COUNT_WIDTH-1:0] tdd_burst_count;
    logic [REGISTER_WIDTH-1:0]    tdd_counter;
    logic [1:0]                   tdd_cstate;
    logic                         tdd_tstart;
    logic                         tdd_endof_frame;
`ifdef TDD_NG_FRAME_INDEX_EN
    logic [BURST_COUNT_WIDTH-1:0] tdd_frame_index;
`endif

    modport master (
        output tdd_enable, tdd_sync, tdd_sync_rst,
        output tdd_startup_delay, tdd_frame_length, tdd_burst_count,
`ifdef TDD_NG_FRAME_INDEX_EN
        input  tdd_frame_index,
`endif
        input  tdd_counter, tdd_cstate, tdd_tstart, tdd_endof_frame
    );

    modport slave (
        input  tdd_enable, tdd_sync, tdd_sync_rst,
        input  tdd_startup_delay, tdd_frame_length, tdd_burst_count,
`ifdef TDD_NG_FRAME_INDEX_EN
        output tdd_frame_index,
`endif
        output tdd_counter, tdd_cstate, tdd_tstart, tdd_endof_frame
    );

endinterface

// File: rtl/axi_tdd_ng_counter.sv
// TDD frame timing core: arm, wait for sync, optional startup delay, then a burst of frames.
// Define TDD_NG_FRAME_INDEX_EN to add the per-burst completed-frame index output.
module axi_tdd_ng_counter
    import axi_tdd_ng_pkg::*;
#(
    parameter int REGISTER_WIDTH    = DEFAULT_REGISTER_WIDTH,
    parameter int BURST_COUNT_WIDTH = DEFAULT_BURST_COUNT_WIDTH
) (
    input logic                 clk,
    input logic                 resetn,
    axi_tdd_ng_counter_if.slave tdd
);

    localparam int RW = REGISTER_WIDTH;
    localparam int BW = BURST_COUNT_WIDTH;
    localparam logic [RW-1:0] RW_ZERO = {RW{1'b0}};
    localparam logic [RW-1:0] RW_ONE  = {{(RW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0] BW_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0] BW_ONE  = {{(BW-1){1'b0}}, 1'b1};

    state_t        state_r,   state_s;
    logic [RW-1:0] counter_r, counter_s;
    logic [RW-1:0] delay_r,   delay_s;
    logic [RW-1:0] last_r,    last_s;
    logic [BW-1:0] burst_r,   burst_s;
    logic [BW-1:0] left_r,    left_s;
    logic          tstart_r;
    logic          endof_r;
    logic          restart_s;
    logic          frame_end_s;
    logic          burst_done_s;

    // Sync acceptance and frame-boundary decode on the current state
    always_comb begin
        restart_s    = tdd.tdd_sync &&
                       ((state_r == ARMED) ||
                        (tdd.tdd_sync_rst && ((state_r == WAITING) || (state_r == RUNNING))));
        frame_end_s  = (state_r == RUNNING) && (counter_r == last_r);
        burst_done_s = frame_end_s && (burst_r != BW_ZERO) && (left_r == BW_ONE);
    end

    // Next-state, counter and shadow-register logic
    always_comb begin
        state_s   = state_r;
        counter_s = counter_r;
        delay_s   = delay_r;
        last_s    = last_r;
        burst_s   = burst_r;
        left_s    = left_r;
        if (!tdd.tdd_enable) begin
            state_s   = IDLE;
            counter_s = RW_ZERO;
        end else if (restart_s) begin
            // Frame length 0 is clamped to 1, so the stored last index never wraps
            delay_s   = tdd.tdd_startup_delay;
            last_s    = (tdd.tdd_frame_length == RW_ZERO) ? RW_ZERO
                                                          : (tdd.tdd_frame_length - RW_ONE);
            burst_s   = tdd.tdd_burst_count;
            left_s    = tdd.tdd_burst_count;
            counter_s = RW_ZERO;
            state_s   = (tdd.tdd_startup_delay != RW_ZERO) ? WAITING : RUNNING;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s   = ARMED;
                    counter_s = RW_ZERO;
                end
                ARMED: begin
                    counter_s = RW_ZERO;
                end
                WAITING: begin
                    if (counter_r == (delay_r - RW_ONE)) begin
                        state_s   = RUNNING;
                        counter_s = RW_ZERO;
                    end else begin
                        counter_s = counter_r + RW_ONE;
                    end
                end
                RUNNING: begin
                    if (burst_done_s) begin
                        state_s   = ARMED;
                        counter_s = RW_ZERO;
                    end else if (frame_end_s) begin
                        counter_s = RW_ZERO;
                        left_s    = left_r - BW_ONE;
                    end else begin
                        counter_s = counter_r + RW_ONE;
                    end
                end
                default: begin
                    state_s   = IDLE;
                    counter_s = RW_ZERO;
                end
            endcase
        end
    end

    // State, counter, shadows and strobes; strobes decode the next state so they align with the counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= IDLE;
            counter_r <= RW_ZERO;
            delay_r   <= RW_ZERO;
            last_r    <= RW_ZERO;
            burst_r   <= BW_ZERO;
            left_r    <= BW_ZERO;
            tstart_r  <= 1'b0;
            endof_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            counter_r <= counter_s;
            delay_r   <= delay_s;
            last_r    <= last_s;
            burst_r   <= burst_s;
            left_r    <= left_s;
            tstart_r  <= (state_s == RUNNING) && (counter_s == RW_ZERO);
            endof_r   <= (state_s == RUNNING) && (counter_s == last_s);
        end
    end

    assign tdd.tdd_counter     = counter_r;
    assign tdd.tdd_cstate      = state_r;
    assign tdd.tdd_tstart      = tstart_r;
    assign tdd.tdd_endof_frame = endof_r;

`ifdef TDD_NG_FRAME_INDEX_EN
    logic [BW-1:0] index_r, index_s;

    // Completed frames in the current burst; cleared on any burst (re)start or exit
    always_comb begin
        index_s = index_r;
        if (!tdd.tdd_enable || restart_s || burst_done_s) begin
            index_s = BW_ZERO;
        end else if (frame_end_s) begin
            index_s = index_r + BW_ONE;
        end else if ((state_r != WAITING) && (state_r != RUNNING)) begin
            index_s = BW_ZERO;
        end else begin
            index_s = index_r;
        end
    end

    // Frame index register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            index_r <= BW_ZERO;
        end else begin
            index_r <= index_s;
        end
    end

    assign tdd.tdd_frame_index = index_r;
`endif

endmodule

// File: tb/tb_axi_tdd_ng_counter.sv
// Self-checking bench for axi_tdd_ng_counter: directed scenarios plus random traffic against
// a timeline model (position since accepted sync -> delay/frame/offset by division).
module tb_axi_tdd_ng_counter;
    import axi_tdd_ng_pkg::*;

    logic clk;
    logic resetn;

    axi_tdd_ng_counter_if #(.REGISTER_WIDTH(32), .BURST_COUNT_WIDTH(32)) bus ();

    axi_tdd_ng_counter #(.REGISTER_WIDTH(32), .BURST_COUNT_WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .tdd    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: enabled flag, active burst flag, cycles since accepted sync, latched settings
    bit     m_en;
    bit     m_act;
    longint m_t;
    longint sh_delay;
    longint sh_len;
    longint sh_burst;

    function automatic void m_reset();
        m_en = 1'b0; m_act = 1'b0; m_t = 0;
        sh_delay = 0; sh_len = 1; sh_burst = 0;
    endfunction

    function automatic void exp_out(output longint st, output longint cnt, output longint ts,
                                    output longint eo, output longint idx);
        longint p;
        st = IDLE; cnt = 0; ts = 0; eo = 0; idx = 0;
        if (m_en && !m_act) begin
            st = ARMED;
        end else if (m_en && m_act) begin
            if (m_t < sh_delay) begin
                st  = WAITING;
                cnt = m_t;
            end else begin
                p   = m_t - sh_delay;
                st  = RUNNING;
                cnt = p % sh_len;
                ts  = (cnt == 0) ? 1 : 0;
                eo  = (cnt == sh_len - 1) ? 1 : 0;
                idx = (p / sh_len) & 64'hFFFF_FFFF;
            end
        end
    endfunction

    function automatic void model_clock();
        longint st, cnt, ts, eo, idx;
        bit acc;
        exp_out(st, cnt, ts, eo, idx);
        if (!bus.tdd_enable) begin
            m_en = 1'b0; m_act = 1'b0;
        end else if (!m_en) begin
            m_en = 1'b1;
        end else begin
            acc = bus.tdd_sync && ((st == ARMED) ||
                  (bus.tdd_sync_rst && ((st == WAITING) || (st == RUNNING))));
            if (acc) begin
                sh_delay = longint'(bus.tdd_startup_delay);
                sh_len   = (bus.tdd_frame_length == 32'd0) ? 1 : longint'(bus.tdd_frame_length);
                sh_burst = longint'(bus.tdd_burst_count);
                m_act    = 1'b1;
                m_t      = 0;
            end else if (m_act) begin
                m_t = m_t + 1;
                if (sh_burst != 0 && m_t >= sh_delay && (m_t - sh_delay) / sh_len >= sh_burst)
                    m_act = 1'b0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        longint st, cnt, ts, eo, idx;
        exp_out(st, cnt, ts, eo, idx);
        chk({tag, ".counter"}, 64'(bus.tdd_counter), cnt);
        chk({tag, ".cstate"},  64'(bus.tdd_cstate), st);
        chk({tag, ".tstart"},  64'(bus.tdd_tstart), ts);
        chk({tag, ".endof"},   64'(bus.tdd_endof_frame), eo);
`ifdef TDD_NG_FRAME_INDEX_EN
        chk({tag, ".index"},   64'(bus.tdd_frame_index), idx);
`endif
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    task automatic pulse_sync(input string tag);
        bus.tdd_sync = 1'b1;
        cycle(tag);
        bus.tdd_sync = 1'b0;
    endtask

    task automatic set_cfg(input int d, input int l, input int b);
        bus.tdd_startup_delay = 32'(d);
        bus.tdd_frame_length  = 32'(l);
        bus.tdd_burst_count   = 32'(b);
    endtask

    initial begin
        bit found;
        longint st, cnt, ts, eo, idx;

        bus.tdd_enable = 1'b0; bus.tdd_sync = 1'b0; bus.tdd_sync_rst = 1'b0;
        set_cfg(0, 0, 0);
        m_reset();
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #2;
        check_all("reset");
        chk("reset.cstate_const", 64'(bus.tdd_cstate), 64'(IDLE));
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // 1: delay 0, len 4, burst 2
        set_cfg(0, 4, 2);
        bus.tdd_enable = 1'b1;
        cycle("t1_arm");
        cycle("t1_armed");
        pulse_sync("t1_sync");
        chk("t1.first_tstart", 64'(bus.tdd_tstart), 64'd1);
        chk("t1.first_state",  64'(bus.tdd_cstate), 64'(RUNNING));
        for (int i = 0; i < 8; i++) cycle("t1_run");
        chk("t1.back_armed", 64'(bus.tdd_cstate), 64'(ARMED));

        // 2: delay 3, len 2, burst 1
        set_cfg(3, 2, 1);
        pulse_sync("t2_sync");
        chk("t2.wait_state", 64'(bus.tdd_cstate), 64'(WAITING));
        cycle("t2_w1");
        cycle("t2_w2");
        chk("t2.wait_cnt2", 64'(bus.tdd_counter), 64'd2);
        cycle("t2_run");
        chk("t2.tstart", 64'(bus.tdd_tstart), 64'd1);
        cycle("t2_end");
        cycle("t2_armed");

        // 3: len 0 clamps to 1, burst 3
        set_cfg(0, 0, 3);
        pulse_sync("t3_sync");
        chk("t3.both_strobes", {62'd0, bus.tdd_tstart, bus.tdd_endof_frame}, 64'd3);
        for (int i = 0; i < 3; i++) cycle("t3_run");
        chk("t3.back_armed", 64'(bus.tdd_cstate), 64'(ARMED));

        // 4: infinite burst, sync restart with sync_rst=1, then ignored with sync_rst=0
        set_cfg(0, 5, 0);
        bus.tdd_sync_rst = 1'b1;
        pulse_sync("t4_sync");
        cycle("t4_c1");
        cycle("t4_c2");
        pulse_sync("t4_restart");
        chk("t4.restart_cnt", 64'(bus.tdd_counter), 64'd0);
        chk("t4.restart_ts",  64'(bus.tdd_tstart), 64'd1);
        bus.tdd_sync_rst = 1'b0;
        cycle("t4_d1");
        cycle("t4_d2");
        pulse_sync("t4_ignored");
        chk("t4.ignored_cnt", 64'(bus.tdd_counter), 64'd3);

        // 5: enable drop coincident with frame end, then async reset mid-WAITING
        set_cfg(0, 3, 0);
        bus.tdd_sync_rst = 1'b1;
        pulse_sync("t5_sync");
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            exp_out(st, cnt, ts, eo, idx);
            if (eo != 0) found = 1'b1;
            else cycle("t5_seek");
        end
        chk("t5.endof_found", 64'(found), 64'd1);
        bus.tdd_enable = 1'b0;
        cycle("t5_drop");
        chk("t5.idle",    64'(bus.tdd_cstate), 64'(IDLE));
        chk("t5.no_ts",   64'(bus.tdd_tstart), 64'd0);
        bus.tdd_enable = 1'b1;
        set_cfg(5, 2, 1);
        cycle("t5_arm");
        pulse_sync("t5_sync2");
        cycle("t5_w1");
        cycle("t5_w2");
        #3 resetn = 1'b0;
        #1;
        m_reset();
        check_all("t5_async");
        chk("t5.async_cnt", 64'(bus.tdd_counter), 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Random traffic: settings and syncs change freely to exercise shadowing
        for (int i = 0; i < 400; i++) begin
            bus.tdd_enable   = ($urandom_range(0, 24) != 0);
            bus.tdd_sync     = ($urandom_range(0, 5) == 0);
            bus.tdd_sync_rst = $urandom_range(0, 1) != 0;
            set_cfg($urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 3));
            cycle("rand");
        end
        bus.tdd_sync = 1'b0;

        // 6: len 2 infinite burst, index climbs, then enable drop
        bus.tdd_enable = 1'b0;
        cycle("t6_idle");
        bus.tdd_enable = 1'b1;
        bus.tdd_sync_rst = 1'b0;
        set_cfg(0, 2, 0);
        cycle("t6_arm");
        pulse_sync("t6_sync");
        for (int i = 0; i < 9; i++) cycle("t6_run");
        bus.tdd_enable = 1'b0;
        cycle("t6_drop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
